regfile_multiport: RTL and testbench



---
 rtl/regfile_multiport.sv | 163 ++++++++++++++++
 tb/tb_regfile_multiport.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// Multiport register file: 2 combinational reads, 2 clocked writes, clear-on-reset sequencer, streamed image load.
// Optional same-cycle write-to-read forwarding in RUN when REGFILE_BYPASS_EN is defined.
module regfile_multiport #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr0,
    output logic [DATA_W-1:0]          rd_data0,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr1,
    output logic [DATA_W-1:0]          rd_data1,
    input  logic                       we0,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr0,
    input  logic [DATA_W-1:0]          wr_data0,
    input  logic                       we1,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr1,
    input  logic [DATA_W-1:0]          wr_data1,
    input  logic                       load_start,
    input  logic                       load_valid,
    input  logic [DATA_W-1:0]          load_data,
    output logic                       ready,
    output logic                       load_done
);

    // state | meaning
    // INIT  | clearing mem[idx] one entry per cycle after reset
    // RUN   | normal operation, both write ports active
    // LOAD  | streaming image words into mem[idx] on load_valid

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_LOAD
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   idx, idx_nxt;
    logic                load_done_nxt;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                seq_we;
    logic [DATA_W-1:0]   seq_data;
    logic                run_we0, run_we1;
    logic                seq_en, wr_en0, wr_en1;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            idx       <= '0;
            load_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            load_done <= load_done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        load_done_nxt = 1'b0;
        seq_we        = 1'b0;
        seq_data      = '0;
        run_we0       = 1'b0;
        run_we1       = 1'b0;
        case (state)
            ST_INIT: begin
                seq_we  = 1'b1;
                idx_nxt = idx + 1'b1;
                if (idx == IDX_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                run_we0 = we0;
                run_we1 = we1;
                if (load_start) begin
                    state_nxt = ST_LOAD;
                    idx_nxt   = '0;
                end
            end
            ST_LOAD: begin
                if (load_valid) begin
                    seq_we   = 1'b1;
                    seq_data = load_data;
                    idx_nxt  = idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        state_nxt     = ST_RUN;
                        load_done_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_INIT;
                idx_nxt   = '0;
            end
        endcase
    end

    assign ready = (state == ST_RUN);

    // Hard-wired zero entry drops writes from every source, including the
    // INIT clear and the word consumed at idx 0 during LOAD.
    assign seq_en = seq_we  && !is_zero(idx);
    assign wr_en0 = run_we0 && !is_zero(wr_addr0);
    assign wr_en1 = run_we1 && !is_zero(wr_addr1);

    // Port 1 is assigned last so it wins an address collision with port 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (seq_en) begin
                mem[idx] <= seq_data;
            end
            if (wr_en0) begin
                mem[wr_addr0] <= wr_data0;
            end
            if (wr_en1) begin
                mem[wr_addr1] <= wr_data1;
            end
        end
    end

    always_comb begin
        rd_data0 = mem[rd_addr0];
`ifdef REGFILE_BYPASS_EN
        if (wr_en0 && (wr_addr0 == rd_addr0)) begin
            rd_data0 = wr_data0;
        end
        if (wr_en1 && (wr_addr1 == rd_addr0)) begin
            rd_data0 = wr_data1;
        end
`endif
        if (is_zero(rd_addr0)) begin
            rd_data0 = '0;
        end
    end

    always_comb begin
        rd_data1 = mem[rd_addr1];
`ifdef REGFILE_BYPASS_EN
        if (wr_en0 && (wr_addr0 == rd_addr1)) begin
            rd_data1 = wr_data0;
        end
        if (wr_en1 && (wr_addr1 == rd_addr1)) begin
            rd_data1 = wr_data1;
        end
`endif
        if (is_zero(rd_addr1)) begin
            rd_data1 = '0;
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench: two instances (ZERO_REG=1 and 0) driven in lockstep against an array-based model.
module tb_regfile_multiport;
    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] rd_addr0 = '0, rd_addr1 = '0, wr_addr0 = '0, wr_addr1 = '0;
    logic [DW-1:0] wr_data0 = '0, wr_data1 = '0, load_data = '0;
    logic          we0 = 1'b0, we1 = 1'b0, load_start = 1'b0, load_valid = 1'b0;

    logic [DW-1:0] z_rd0, z_rd1, n_rd0, n_rd1;
    logic          z_ready, n_ready, z_done, n_done;

    regfile_multiport #(.DATA_W(DW), .DEPTH(DEPTH), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst(rst),
        .rd_addr0(rd_addr0), .rd_data0(z_rd0), .rd_addr1(rd_addr1), .rd_data1(z_rd1),
        .we0(we0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .we1(we1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .ready(z_ready), .load_done(z_done)
    );

    regfile_multiport #(.DATA_W(DW), .DEPTH(DEPTH), .ZERO_REG(0)) dut_n (
        .clk(clk), .rst(rst),
        .rd_addr0(rd_addr0), .rd_data0(n_rd0), .rd_addr1(rd_addr1), .rd_data1(n_rd1),
        .we0(we0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .we1(we1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .ready(n_ready), .load_done(n_done)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] mz [DEPTH];
    logic [DW-1:0] mn [DEPTH];
    bit            in_run = 1'b0;

    typedef struct {
        logic          we0;
        logic [AW-1:0] wa0;
        logic [DW-1:0] wd0;
        logic          we1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic [AW-1:0] ra;
        logic [DW-1:0] exp_z;
        logic [DW-1:0] exp_n;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] expect_rd(input bit zr, input logic [AW-1:0] a);
        logic [DW-1:0] v;
        if (zr && a == '0) return '0;
        v = zr ? mz[a] : mn[a];
`ifdef REGFILE_BYPASS_EN
        if (in_run) begin
            if (we0 && wr_addr0 == a) v = wr_data0;
            if (we1 && wr_addr1 == a) v = wr_data1;
        end
`endif
        return v;
    endfunction

    task automatic commit();
        if (in_run) begin
            if (we0) begin
                if (wr_addr0 != '0) mz[wr_addr0] = wr_data0;
                mn[wr_addr0] = wr_data0;
            end
            if (we1) begin
                if (wr_addr1 != '0) mz[wr_addr1] = wr_data1;
                mn[wr_addr1] = wr_data1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reads(input string tag);
        chk({tag, " z_rd0"}, z_rd0, expect_rd(1'b1, rd_addr0));
        chk({tag, " z_rd1"}, z_rd1, expect_rd(1'b1, rd_addr1));
        chk({tag, " n_rd0"}, n_rd0, expect_rd(1'b0, rd_addr0));
        chk({tag, " n_rd1"}, n_rd1, expect_rd(1'b0, rd_addr1));
    endtask

    task automatic step(input string tag);
        #2;
        check_reads(tag);
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr0 = AW'(a);
            rd_addr1 = AW'(DEPTH - 1 - a);
            #1;
            check_reads(tag);
        end
    endtask

    // Reset, then INIT with writes and load_start asserted to prove they are ignored.
    task automatic reset_and_init();
        in_run     = 1'b0;
        rst        = 1'b1;
        load_valid = 1'b0;
        we0        = 1'b1;
        wr_addr0   = AW'(1);
        wr_data0   = 32'hBADC0DE1;
        load_start = 1'b1;
        repeat (2) tick();
        chk("reset ready", {31'd0, z_ready}, 32'd0);
        chk("reset load_done", {31'd0, z_done}, 32'd0);
        rst = 1'b0;
        for (int c = 0; c < DEPTH; c++) begin
            chk("init ready", {31'd0, z_ready | n_ready}, 32'd0);
            chk("init load_done", {31'd0, z_done | n_done}, 32'd0);
            tick();
        end
        we0        = 1'b0;
        load_start = 1'b0;
        chk("ready after init z", {31'd0, z_ready}, 32'd1);
        chk("ready after init n", {31'd0, n_ready}, 32'd1);
        for (int a = 0; a < DEPTH; a++) begin
            mz[a] = '0;
            mn[a] = '0;
        end
        in_run = 1'b1;
        read_all("after init");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i, cyc;

        tbl[0] = '{1'b1, 5'd5,  32'h11111111, 1'b1, 5'd5,  32'h22222222, 5'd5,  32'h22222222, 32'h22222222};
        tbl[1] = '{1'b1, 5'd0,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        5'd0,  32'h0,        32'hDEADBEEF};
        tbl[2] = '{1'b1, 5'd3,  32'h00000033, 1'b1, 5'd4,  32'h00000044, 5'd3,  32'h00000033, 32'h00000033};
        tbl[3] = '{1'b0, 5'd3,  32'hFFFF0000, 1'b0, 5'd4,  32'hFFFF0000, 5'd4,  32'h00000044, 32'h00000044};
        tbl[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h00000055, 5'd0,  32'h0,        32'h00000055};
        tbl[5] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF};
        tbl[6] = '{1'b1, 5'd9,  32'h00000099, 1'b1, 5'd10, 32'h00001010, 5'd9,  32'h00000099, 32'h00000099};

        reset_and_init();

        // Same-cycle read of a write in flight.
        we0 = 1'b1; wr_addr0 = AW'(7); wr_data0 = 32'hA5A5A5A5;
        we1 = 1'b1; wr_addr1 = AW'(0); wr_data1 = 32'h00000077;
        rd_addr0 = AW'(7); rd_addr1 = AW'(0);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass addr7", z_rd0, 32'hA5A5A5A5);
        chk("bypass zero reg", z_rd1, 32'h0);
        chk("bypass addr0 no zero reg", n_rd1, 32'h00000077);
`else
        chk("no bypass addr7", z_rd0, 32'h0);
        chk("no bypass addr0", n_rd1, 32'h0);
`endif
        step("bypass");
        we0 = 1'b0; we1 = 1'b0;
        #1;
        chk("addr7 after write", z_rd0, 32'hA5A5A5A5);

        for (int k = 0; k < 7; k++) begin
            we0 = tbl[k].we0; wr_addr0 = tbl[k].wa0; wr_data0 = tbl[k].wd0;
            we1 = tbl[k].we1; wr_addr1 = tbl[k].wa1; wr_data1 = tbl[k].wd1;
            rd_addr0 = AW'(30); rd_addr1 = AW'(30);
            @(posedge clk);
            commit();
            #1;
            we0 = 1'b0; we1 = 1'b0;
            rd_addr0 = tbl[k].ra; rd_addr1 = tbl[k].ra;
            #1;
            chk($sformatf("table[%0d] z_rd0", k), z_rd0, tbl[k].exp_z);
            chk($sformatf("table[%0d] z_rd1", k), z_rd1, tbl[k].exp_z);
            chk($sformatf("table[%0d] n_rd0", k), n_rd0, tbl[k].exp_n);
            chk($sformatf("table[%0d] n_rd1", k), n_rd1, tbl[k].exp_n);
        end

        for (int k = 0; k < 400; k++) begin
            we0 = 1'($urandom_range(0, 1)); wr_addr0 = AW'($urandom_range(0, 7)); wr_data0 = $urandom;
            we1 = 1'($urandom_range(0, 1)); wr_addr1 = AW'($urandom_range(0, 7)); wr_data1 = $urandom;
            rd_addr0 = AW'($urandom_range(0, 7)); rd_addr1 = AW'($urandom_range(0, 7));
            step("random");
        end
        we0 = 1'b0; we1 = 1'b0;

        // Image load with gaps, a stray write and a stray load_start mid-stream.
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        in_run = 1'b0;
        i = 0;
        cyc = 0;
        while (i < DEPTH && cyc < 100) begin
            we0 = 1'b1; wr_addr0 = AW'(20); wr_data0 = 32'h0BAD0BAD;
            load_start = (cyc == 8);
            if (cyc == 4 || cyc == 13 || cyc == 27) begin
                load_valid = 1'b0;
            end else begin
                load_valid = 1'b1;
                load_data  = 32'h100 + DW'(i);
            end
            chk("load ready low", {31'd0, z_ready}, 32'd0);
            tick();
            if (load_valid) i++;
            cyc++;
            if (i < DEPTH) chk("load_done early", {31'd0, z_done}, 32'd0);
        end
        if (i < DEPTH) chk("load words accepted", DW'(i), DW'(DEPTH));
        load_valid = 1'b0; load_start = 1'b0; we0 = 1'b0;
        chk("load_done pulse z", {31'd0, z_done}, 32'd1);
        chk("load_done pulse n", {31'd0, n_done}, 32'd1);
        chk("ready after load", {31'd0, z_ready}, 32'd1);
        tick();
        chk("load_done one cycle", {31'd0, z_done | n_done}, 32'd0);
        for (int a = 0; a < DEPTH; a++) begin
            mz[a] = (a == 0) ? 32'h0 : 32'h100 + DW'(a);
            mn[a] = 32'h100 + DW'(a);
        end
        in_run = 1'b1;
        read_all("after load");

        // Reset ten words into a load.
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        in_run = 1'b0;
        for (int k = 0; k < 10; k++) begin
            load_valid = 1'b1;
            load_data  = 32'hC0DE0000 + DW'(k);
            tick();
        end
        load_valid = 1'b0;
        reset_and_init();
        for (int k = 0; k < 4; k++) begin
            chk("no load_done after mid-load reset", {31'd0, z_done | n_done}, 32'd0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
